// File: rtl/stopwatch_button_conditioner.sv
// stopwatch_button_conditioner: sync, debounce and arm the stopwatch buttons/switch, emit prioritised command pulses
module stopwatch_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_lap,
  input  logic btn_reset,
  input  logic sw_up,
  output logic start_pulse,
  output logic stop_pulse,
  output logic lap_pulse,
  output logic reset_pulse,
  output logic up_level
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_FIRED} r_state_t;
  logic [4:0] raw, s1, s2, stable;
  logic [3:0] stable_d, armed, ev;
  logic [1:0] fill;
  logic [DW-1:0] cnt [5];
  logic [HW-1:0] hcnt;
  logic up_d;
  r_state_t state;
  assign raw = {sw_up, btn_reset, btn_lap, btn_stop, btn_start};
  // fill[1] marks s2 as carrying real input samples; a button only arms once a genuine low is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      stable <= 5'b10000;
      stable_d <= '0;
      fill <= '0;
      armed <= '0;
      ev <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stable_d <= stable[3:0];
      fill <= {fill[0], 1'b1};
      armed <= armed | ({4{fill[1]}} & ~stable[3:0] & ~s2[3:0]);
      ev <= stable[3:0] & ~stable_d & armed;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      start_pulse <= 1'b0;
      stop_pulse <= 1'b0;
      lap_pulse <= 1'b0;
      reset_pulse <= 1'b0;
      up_d <= 1'b1;
      up_level <= 1'b1;
      state <= R_IDLE;
      hcnt <= '0;
    end else begin
      stop_pulse <= ev[1];
      start_pulse <= ev[0] & ~ev[1];
      lap_pulse <= ev[2] & ~ev[0] & ~ev[1];
      up_d <= stable[4];
      up_level <= up_d;
      reset_pulse <= 1'b0;
      case (state)
        R_IDLE: if (ev[3]) begin
          state <= R_HOLD;
          hcnt <= '0;
        end
        R_HOLD: if (!stable[3]) state <= R_IDLE;
        else if (hcnt == HW'(HOLD_CYCLES - 1)) begin
          state <= R_FIRED;
          reset_pulse <= 1'b1;
        end else hcnt <= hcnt + 1'b1;
        R_FIRED: if (!stable[3]) state <= R_IDLE;
        default: state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stopwatch_button_conditioner.sv
// tb_stopwatch_button_conditioner: directed + random stimulus, reference model feeds a scoreboard queue
module tb_stopwatch_button_conditioner;
  localparam int D = 4;
  localparam int H = 10;
  logic clk = 1'b0, reset = 1'b1;
  logic btn_start = 1'b0, btn_stop = 1'b0, btn_lap = 1'b0, btn_reset = 1'b0, sw_up = 1'b1;
  logic start_pulse, stop_pulse, lap_pulse, reset_pulse, up_level;
  stopwatch_button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_lap(btn_lap), .btn_reset(btn_reset), .sw_up(sw_up),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .lap_pulse(lap_pulse),
    .reset_pulse(reset_pulse), .up_level(up_level)
  );
  always #5 clk = ~clk;
  logic [4:0] expq[$];
  int nvec = 0, nerr = 0;
  // reference model: raw sample history per input (two leading zeros = cleared synchroniser)
  bit hist[5][$];
  bit dbh[5][$];
  bit rqh[4][$];
  bit armed[4];
  int e, deadline;
  task automatic model_clear();
    for (int i = 0; i < 5; i++) begin
      hist[i].delete();
      hist[i].push_back(1'b0);
      hist[i].push_back(1'b0);
      dbh[i].delete();
    end
    for (int i = 0; i < 4; i++) begin
      rqh[i].delete();
      armed[i] = 1'b0;
    end
    e = 0;
    deadline = -1;
  endtask
  // level accepted once the synchronised input has disagreed for D consecutive samples since reset;
  // commands appear two cycles after the accepted rise, long-press reset fires H cycles after that
  task automatic step(input bit [4:0] r, output logic [4:0] x);
    bit prev, cur, flip, a, b, c, d, up;
    for (int i = 0; i < 5; i++) begin
      hist[i].push_back(r[i]);
      prev = (e == 0) ? (i == 4) : dbh[i][e-1];
      flip = (e >= 3);
      for (int j = 2; j <= 5; j++) if (hist[i][e-j+2] == prev) flip = 1'b0;
      cur = flip ? !prev : prev;
      dbh[i].push_back(cur);
      if (i < 4) begin
        if (e >= 2 && !prev && !hist[i][e]) armed[i] = 1'b1;
        rqh[i].push_back(cur && !prev && armed[i]);
      end
    end
    {a, b, c, d} = (e >= 2) ? {rqh[0][e-2], rqh[1][e-2], rqh[2][e-2], rqh[3][e-2]} : 4'b0;
    if (d) deadline = e + H;
    if (deadline > e && !dbh[3][e]) deadline = -1;
    up = (e >= 2) ? dbh[4][e-2] : 1'b1;
    x = {a & ~b, b, c & ~a & ~b, deadline == e, up};
    e++;
  endtask
  task automatic tick(input bit rs, input bit [4:0] r);
    logic [4:0] x;
    reset = rs;
    {sw_up, btn_reset, btn_lap, btn_stop, btn_start} = r;
    if (rs) begin
      model_clear();
      x = 5'b00001;
    end else step(r, x);
    expq.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic hold(input int n, input bit [4:0] r);
    repeat (n) tick(1'b0, r);
  endtask
  initial begin
    logic [4:0] x, got;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        x = expq.pop_front();
        got = {start_pulse, stop_pulse, lap_pulse, reset_pulse, up_level};
        nvec++;
        if (got !== x) begin
          nerr++;
          $display("FAIL outputs vec %0d: start/stop/lap/rst/up got %b expected %b", nvec, got, x);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors checked", nvec);
    $fatal(1);
  end
  initial begin
    bit [4:0] tgt, r;
    model_clear();
    repeat (3) tick(1'b1, 5'b10000);
    hold(10, 5'b10000);
    hold(20, 5'b10001); hold(12, 5'b10000);
    for (int k = 0; k < 2; k++) begin
      hold(2, 5'b10010); hold(2, 5'b10000);
    end
    hold(15, 5'b10010); hold(12, 5'b10000);
    hold(15, 5'b10011); hold(12, 5'b10000);
    hold(8, 5'b11000); hold(12, 5'b10000);
    hold(40, 5'b11000); hold(12, 5'b10000);
    hold(6, 5'b10100);
    repeat (3) tick(1'b1, 5'b10100);
    hold(15, 5'b10100); hold(12, 5'b10000);
    hold(15, 5'b10100); hold(12, 5'b10000);
    hold(6, 5'b00000);
    repeat (2) tick(1'b1, 5'b00000);
    hold(15, 5'b00000); hold(12, 5'b10000);
    tgt = 5'b10000;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(39) == 0) tgt[i] = !tgt[i];
      r = tgt;
      for (int i = 0; i < 5; i++) if ($urandom_range(9) == 0) r[i] = !r[i];
      tick($urandom_range(299) == 0, r);
    end
    hold(20, 5'b10000);
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
